ballot_capture: RTL



---
 rtl/evm_pkg.sv | 31 +++
 rtl/ballot_capture_btn_sync.sv | 25 ++
 rtl/ballot_capture.sv | 137 +++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared types and constants for the ballot front-end and vote counters.
package evm_pkg;

  localparam int NUM_CANDIDATES     = 4;
  localparam int DEF_HOLD_CYCLES    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 60;

  typedef logic [1:0] candidate_id_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HOLD,
    COMMIT,
    LOCKOUT
  } ballot_state_t;

  function automatic logic is_onehot(input logic [NUM_CANDIDATES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic candidate_id_t encode_onehot(input logic [NUM_CANDIDATES-1:0] v);
    candidate_id_t id;
    id = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (v[i]) id = candidate_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/ballot_capture_btn_sync.sv
// Multi-flop synchroniser for the raw candidate buttons; clears to 0 on reset.
module btn_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/ballot_capture.sv
// Qualifies a single stable button press per armed session and emits one vote strobe.
// Optional BALLOT_CAPTURE_ACK_EN adds a vote_ready handshake that holds COMMIT.
module ballot_capture
  import evm_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      session_start,
  input  logic [NUM_CANDIDATES-1:0] button,
`ifdef BALLOT_CAPTURE_ACK_EN
  input  logic                      vote_ready,
`endif
  output logic                      armed,
  output logic [NUM_CANDIDATES-1:0] led,
  output logic                      vote_valid,
  output candidate_id_t             vote_id,
  output logic                      multi_press,
  output logic                      timeout
);

  localparam logic [7:0]  HOLD_LIM = 8'(HOLD_CYCLES);
  localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYCLES);

  logic [NUM_CANDIDATES-1:0] sb;
  logic [NUM_CANDIDATES-1:0] cand_onehot;
  logic                      sb_onehot;
  logic                      sb_multi;
  logic                      expire;

  ballot_state_t state, state_nxt;
  logic [7:0]    hold_cnt, hold_nxt;
  logic [15:0]   sess_cnt, sess_nxt;
  candidate_id_t cand, cand_nxt;
  logic          multi_nxt, timeout_nxt;

  btn_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (NUM_CANDIDATES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (button),
    .dout  (sb)
  );

  assign sb_onehot   = is_onehot(sb);
  assign sb_multi    = (sb != '0) && !sb_onehot;
  assign cand_onehot = 4'b0001 << cand;
  assign expire      = ((sess_cnt + 16'd1) == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      sess_cnt    <= '0;
      cand        <= '0;
      multi_press <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      sess_cnt    <= sess_nxt;
      cand        <= cand_nxt;
      multi_press <= multi_nxt;
      timeout     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    sess_nxt    = sess_cnt;
    cand_nxt    = cand;
    multi_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (session_start) begin
          state_nxt = ARMED;
          sess_nxt  = '0;
          hold_nxt  = '0;
        end
      end
      ARMED: begin
        sess_nxt = sess_cnt + 16'd1;
        if (sb_onehot) begin
          cand_nxt  = encode_onehot(sb);
          hold_nxt  = 8'd1;
          state_nxt = (HOLD_LIM == 8'd1) ? COMMIT : HOLD;
        end else if (sb_multi) begin
          multi_nxt = 1'b1;
        end
      end
      HOLD: begin
        sess_nxt = sess_cnt + 16'd1;
        if (sb == cand_onehot) begin
          hold_nxt = hold_cnt + 8'd1;
          if ((hold_cnt + 8'd1) == HOLD_LIM) state_nxt = COMMIT;
        end else begin
          // Any break in the press, including a multi-press, restarts qualification.
          state_nxt = ARMED;
          hold_nxt  = '0;
          multi_nxt = sb_multi;
        end
      end
      COMMIT: begin
        hold_nxt = '0;
`ifdef BALLOT_CAPTURE_ACK_EN
        if (vote_ready) state_nxt = LOCKOUT;
`else
        state_nxt = LOCKOUT;
`endif
      end
      LOCKOUT: begin
        if (sb == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Expiry yields to a vote committing on the same edge.
    if ((state == ARMED || state == HOLD) && expire && state_nxt != COMMIT) begin
      state_nxt   = IDLE;
      hold_nxt    = '0;
      timeout_nxt = 1'b1;
    end
  end

  assign armed      = (state == ARMED) || (state == HOLD);
  assign vote_valid = (state == COMMIT);
  assign vote_id    = vote_valid ? cand : '0;
  assign led        = (state == HOLD || state == COMMIT || state == LOCKOUT) ? cand_onehot : '0;

endmodule
